// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / load-store) arbiter in front of the single memory_com port.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_write_enable,
    output logic              m_read_enable,
    output logic [ADDR_W-1:0] m_address,
    output logic [DATA_W-1:0] m_writeData,
    input  logic [DATA_W-1:0] m_readData,
    input  logic              m_done,
    output logic              busy,
    output logic              grant_d
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_GAP
    } state_t;

    state_t            r_state;
    logic [3:0]        r_gap_cnt;
    logic              r_grant_d;
    logic              r_wen;
    logic              r_ren;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_ack;
    logic              r_d_ack;
    logic              r_busy;
    logic              w_pick_d;

`ifdef MEM_ARB_RR_EN
    // r_grant_d doubles as the last-owner register: on a tie the other port wins.
    assign w_pick_d = d_req & (~i_req | ~r_grant_d);
`else
    assign w_pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= 4'd0;
            r_grant_d <= 1'b0;
            r_wen     <= 1'b0;
            r_ren     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req || d_req) begin
                        r_grant_d <= w_pick_d;
                        r_addr    <= w_pick_d ? d_addr : i_addr;
                        r_wdata   <= w_pick_d ? d_wdata : '0;
                        r_wen     <= w_pick_d & d_we;
                        r_ren     <= ~(w_pick_d & d_we);
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (m_done) begin
                        r_wen <= 1'b0;
                        r_ren <= 1'b0;
                        if (r_grant_d) begin
                            r_d_ack <= 1'b1;
                            if (!r_wen) begin
                                r_d_rdata <= m_readData;
                            end
                        end else begin
                            r_i_ack   <= 1'b1;
                            r_i_rdata <= m_readData;
                        end
                        r_state <= S_ACK;
                    end
                end
                S_ACK: begin
                    r_i_ack <= 1'b0;
                    r_d_ack <= 1'b0;
                    if (GAP_CYCLES == 0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= 4'(GAP_CYCLES);
                        r_state   <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_gap_cnt <= 4'd1) begin
                        r_gap_cnt <= 4'd0;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign i_rdata        = r_i_rdata;
    assign i_ack          = r_i_ack;
    assign d_rdata        = r_d_rdata;
    assign d_ack          = r_d_ack;
    assign m_write_enable = r_wen;
    assign m_read_enable  = r_ren;
    assign m_address      = r_addr;
    assign m_writeData    = r_wdata;
    assign busy           = r_busy;
    assign grant_d        = r_grant_d;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// behavioural model of the arbitration rules (fixed or round-robin depending on MEM_ARB_RR_EN).
module tb_mem_arbiter;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int GAP = 3;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req, d_req, d_we, m_done;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, m_readData;
    logic [DW-1:0] i_rdata, d_rdata, m_writeData;
    logic [AW-1:0] m_address;
    logic          i_ack, d_ack, m_write_enable, m_read_enable, busy, grant_d;

    int   n_run  = 0;
    int   n_fail = 0;
    logic m_last_d = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_write_enable(m_write_enable), .m_read_enable(m_read_enable),
        .m_address(m_address), .m_writeData(m_writeData),
        .m_readData(m_readData), .m_done(m_done),
        .busy(busy), .grant_d(grant_d)
    );

    // Reference arbitration rule: who wins when the arbiter is idle.
    function automatic logic pick_d(input logic iq, input logic dq, input logic last_d);
        if (!dq) return 1'b0;
        if (!iq) return 1'b1;
        return RR ? ~last_d : 1'b1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_enable(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if ((m_read_enable | m_write_enable) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Memory side: keep m_done low for lat cycles, then pulse it with rd on readData.
    task automatic finish_mem(input int lat, input logic [DW-1:0] rd, output bit held);
        logic [1:0]    en0;
        logic [AW-1:0] a0;
        logic [DW-1:0] w0;
        en0  = {m_write_enable, m_read_enable};
        a0   = m_address;
        w0   = m_writeData;
        held = 1'b1;
        for (int k = 0; k < lat; k++) begin
            tick();
            if ({m_write_enable, m_read_enable} !== en0 || m_address !== a0 ||
                m_writeData !== w0 || (i_ack | d_ack) !== 1'b0)
                held = 1'b0;
        end
        m_readData = rd;
        m_done     = 1'b1;
        tick();
        m_done     = 1'b0;
        m_readData = $urandom;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        i_req = 0; d_req = 0; d_we = 0; m_done = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; m_readData = '0;
        repeat (3) tick();
        n_run++;
        if ({i_ack, d_ack, m_write_enable, m_read_enable, busy, grant_d} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {i_ack, d_ack, m_write_enable, m_read_enable, busy, grant_d});
        end
        n_run++;
        if ({i_rdata, d_rdata, m_address, m_writeData} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h %h %h %h, expected all 0",
                     i_rdata, d_rdata, m_address, m_writeData);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        n_run++;
        if ({busy, m_read_enable, m_write_enable} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b, expected 000",
                     {busy, m_read_enable, m_write_enable});
        end
    endtask

    task automatic test_i_read();
        bit held, ok;
        i_addr = 32'h0000_0040;
        i_req  = 1'b1;
        tick();
        n_run++;
        if ({m_read_enable, m_write_enable, busy, grant_d, i_ack} !== 5'b10100) begin
            n_fail++;
            $display("FAIL iread_issue: got %b, expected 10100",
                     {m_read_enable, m_write_enable, busy, grant_d, i_ack});
        end
        n_run++;
        if (m_address !== 32'h0000_0040) begin
            n_fail++;
            $display("FAIL iread_addr: got %h, expected 00000040", m_address);
        end
        finish_mem(2, 32'h1234_5678, held);
        n_run++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL iread_hold: got %b, expected 1", held);
        end
        n_run++;
        if ({i_ack, d_ack, m_read_enable, m_write_enable} !== 4'b1000) begin
            n_fail++;
            $display("FAIL iread_ack: got %b, expected 1000",
                     {i_ack, d_ack, m_read_enable, m_write_enable});
        end
        n_run++;
        if (i_rdata !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL iread_data: got %h, expected 12345678", i_rdata);
        end
        i_req = 1'b0;
        tick();
        n_run++;
        if (i_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL iread_ack_pulse: got %b, expected 0", i_ack);
        end
        wait_idle(ok);
        n_run++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL iread_idle_timeout: got %b, expected 1", ok);
        end
        m_last_d = 1'b0;
    endtask

    task automatic test_tie();
        bit            held, ok;
        logic [2:0]    exp_seq;
        logic          exp_d;
        logic [DW-1:0] rd;
        exp_seq = RR ? 3'b101 : 3'b111;
        i_addr = 32'h200; d_addr = 32'h300; d_we = 1'b0;
        i_req  = 1'b1;    d_req  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_d = exp_seq[k];
            wait_enable(ok);
            n_run++;
            if (ok !== 1'b1) begin
                n_fail++;
                $display("FAIL tie_issue_timeout[%0d]: got %b, expected 1", k, ok);
            end
            n_run++;
            if ({grant_d, m_address} !== {exp_d, (exp_d ? 32'h300 : 32'h200)}) begin
                n_fail++;
                $display("FAIL tie_winner[%0d]: got %b/%h, expected %b", k, grant_d, m_address, exp_d);
            end
            rd = $urandom;
            finish_mem($urandom_range(0, 3), rd, held);
            n_run++;
            if ({i_ack, d_ack} !== (exp_d ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL tie_ack[%0d]: got %b, expected %b", k, {i_ack, d_ack},
                         (exp_d ? 2'b01 : 2'b10));
            end
            n_run++;
            if ((exp_d ? d_rdata : i_rdata) !== rd) begin
                n_fail++;
                $display("FAIL tie_rdata[%0d]: got %h, expected %h", k,
                         (exp_d ? d_rdata : i_rdata), rd);
            end
            m_last_d = exp_d;
        end
        i_req = 1'b0; d_req = 1'b0;
        wait_idle(ok);
        n_run++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL tie_idle_timeout: got %b, expected 1", ok);
        end
    endtask

    task automatic test_d_write();
        bit held, ok;
        d_we = 1'b0; d_addr = 32'h104; d_req = 1'b1;
        tick();
        finish_mem(1, 32'hCAFE_F00D, held);
        n_run++;
        if ({d_ack, d_rdata} !== {1'b1, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL dread_pre: got %b/%h, expected 1/cafef00d", d_ack, d_rdata);
        end
        d_req = 1'b0;
        wait_idle(ok);
        d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_req = 1'b1;
        tick();
        n_run++;
        if ({m_write_enable, m_read_enable, m_address, m_writeData} !==
            {2'b10, 32'h100, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL dwrite_issue: got %b%b %h %h, expected 10 00000100 deadbeef",
                     m_write_enable, m_read_enable, m_address, m_writeData);
        end
        finish_mem(3, 32'h5555_AAAA, held);
        n_run++;
        if (held !== 1'b1) begin
            n_fail++;
            $display("FAIL dwrite_hold: got %b, expected 1", held);
        end
        n_run++;
        if ({d_ack, i_ack, m_write_enable} !== 3'b100) begin
            n_fail++;
            $display("FAIL dwrite_ack: got %b, expected 100", {d_ack, i_ack, m_write_enable});
        end
        n_run++;
        if (d_rdata !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL dwrite_rdata_kept: got %h, expected cafef00d", d_rdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        wait_idle(ok);
        m_last_d = 1'b1;
    endtask

    task automatic test_back_to_back();
        bit            held, ok, found;
        int            n_low, n_busy_low;
        logic [DW-1:0] rd;
        d_we = 1'b0; d_addr = 32'h80; d_req = 1'b1;
        wait_enable(ok);
        finish_mem(1, 32'h0101_0101, held);
        n_run++;
        if (d_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_ack: got %b, expected 1", d_ack);
        end
        n_low = 0; n_busy_low = 0; found = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if ((m_read_enable | m_write_enable) === 1'b1) begin
                found = 1'b1;
                break;
            end
            n_low++;
            if (busy === 1'b0) n_busy_low++;
            tick();
        end
        n_run++;
        if ({found, n_low} !== {1'b1, GAP + 2}) begin
            n_fail++;
            $display("FAIL b2b_enable_gap: got found=%b low=%0d, expected found=1 low=%0d",
                     found, n_low, GAP + 2);
        end
        n_run++;
        if (n_busy_low !== 1) begin
            n_fail++;
            $display("FAIL b2b_busy_low: got %0d, expected 1", n_busy_low);
        end
        rd = $urandom;
        finish_mem(2, rd, held);
        n_run++;
        if ({d_ack, d_rdata} !== {1'b1, rd}) begin
            n_fail++;
            $display("FAIL b2b_second: got %b/%h, expected 1/%h", d_ack, d_rdata, rd);
        end
        d_req = 1'b0;
        wait_idle(ok);
        m_last_d = 1'b1;
    endtask

    task automatic test_spurious_and_reset();
        bit held, ok;
        m_readData = 32'h7777_7777;
        m_done = 1'b1;
        tick();
        m_done = 1'b0;
        n_run++;
        if ({i_ack, d_ack, busy, m_read_enable, m_write_enable} !== 5'b0) begin
            n_fail++;
            $display("FAIL spurious_done: got %b, expected 00000",
                     {i_ack, d_ack, busy, m_read_enable, m_write_enable});
        end
        tick();
        n_run++;
        if ({i_ack, d_ack, busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL spurious_done_late: got %b, expected 000", {i_ack, d_ack, busy});
        end
        d_we = 1'b0; d_addr = 32'h44; d_req = 1'b1;
        tick();
        n_run++;
        if ({busy, m_read_enable} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_pre_issue: got %b, expected 11", {busy, m_read_enable});
        end
        #2;
        reset = 1'b0;
        #1;
        n_run++;
        if ({i_ack, d_ack, m_write_enable, m_read_enable, busy, grant_d} !== 6'b0 ||
            {i_rdata, d_rdata, m_address, m_writeData} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got ctrl %b addr %h, expected all 0",
                     {i_ack, d_ack, m_write_enable, m_read_enable, busy, grant_d}, m_address);
        end
        d_req = 1'b0;
        m_done = 1'b1;
        repeat (2) tick();
        m_done = 1'b0;
        n_run++;
        if ({i_ack, d_ack, busy} !== 3'b0) begin
            n_fail++;
            $display("FAIL rst_hold: got %b, expected 000", {i_ack, d_ack, busy});
        end
        @(negedge clk);
        reset = 1'b1;
        i_addr = 32'h48; i_req = 1'b1;
        tick();
        n_run++;
        if ({m_read_enable, m_address} !== {1'b1, 32'h48}) begin
            n_fail++;
            $display("FAIL rst_after_issue: got %b/%h, expected 1/00000048", m_read_enable, m_address);
        end
        finish_mem(1, 32'h0BAD_CAFE, held);
        n_run++;
        if ({i_ack, i_rdata} !== {1'b1, 32'h0BAD_CAFE}) begin
            n_fail++;
            $display("FAIL rst_after_ack: got %b/%h, expected 1/0badcafe", i_ack, i_rdata);
        end
        i_req = 1'b0;
        wait_idle(ok);
        m_last_d = 1'b0;
    endtask

    task automatic test_random();
        bit            held, ok, pend_i, pend_d, known_d, drop;
        logic          exp_d;
        logic [DW-1:0] rd, mdl_d;
        pend_i = 0; pend_d = 0; known_d = 0; mdl_d = '0;
        for (int it = 0; it < 40; it++) begin
            if (!pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; i_addr = $urandom;
            end
            if (!pend_d && $urandom_range(0, 1) == 1) begin
                pend_d = 1; d_addr = $urandom; d_we = $urandom_range(0, 1); d_wdata = $urandom;
            end
            if (!pend_i && !pend_d) begin
                pend_i = 1; i_addr = $urandom;
            end
            i_req = pend_i; d_req = pend_d;
            exp_d = pick_d(pend_i, pend_d, m_last_d);
            tick();
            n_run++;
            if ({grant_d, m_write_enable, m_read_enable} !==
                {exp_d, (exp_d && d_we) ? 2'b10 : 2'b01}) begin
                n_fail++;
                $display("FAIL rnd_issue[%0d]: got %b, expected grant=%b we=%b", it,
                         {grant_d, m_write_enable, m_read_enable}, exp_d, exp_d && d_we);
            end
            n_run++;
            if (m_address !== (exp_d ? d_addr : i_addr) ||
                ((exp_d && d_we) && m_writeData !== d_wdata)) begin
                n_fail++;
                $display("FAIL rnd_addr[%0d]: got %h/%h, expected %h", it, m_address,
                         m_writeData, (exp_d ? d_addr : i_addr));
            end
            // Late request on the other port, and occasional early drop by the winner.
            if (exp_d && !pend_i && $urandom_range(0, 1) == 1) begin
                pend_i = 1; i_addr = $urandom; i_req = 1'b1;
            end
            if (!exp_d && !pend_d && $urandom_range(0, 1) == 1) begin
                pend_d = 1; d_addr = $urandom; d_we = $urandom_range(0, 1); d_wdata = $urandom;
                d_req = 1'b1;
            end
            drop = ($urandom_range(0, 3) == 0);
            if (drop) begin
                if (exp_d) d_req = 1'b0;
                else       i_req = 1'b0;
            end
            rd = $urandom;
            finish_mem($urandom_range(0, 4), rd, held);
            n_run++;
            if ({held, i_ack, d_ack} !== {1'b1, (exp_d ? 2'b01 : 2'b10)}) begin
                n_fail++;
                $display("FAIL rnd_ack[%0d]: got held=%b acks=%b, expected 1/%b", it, held,
                         {i_ack, d_ack}, (exp_d ? 2'b01 : 2'b10));
            end
            if (!exp_d) begin
                n_run++;
                if (i_rdata !== rd) begin
                    n_fail++;
                    $display("FAIL rnd_irdata[%0d]: got %h, expected %h", it, i_rdata, rd);
                end
                pend_i = 0; i_req = 1'b0;
            end else begin
                if (!d_we) begin
                    mdl_d = rd; known_d = 1'b1;
                end
                if (known_d) begin
                    n_run++;
                    if (d_rdata !== mdl_d) begin
                        n_fail++;
                        $display("FAIL rnd_drdata[%0d]: got %h, expected %h", it, d_rdata, mdl_d);
                    end
                end
                pend_d = 0; d_req = 1'b0;
            end
            m_last_d = exp_d;
            wait_idle(ok);
            n_run++;
            if (ok !== 1'b1) begin
                n_fail++;
                $display("FAIL rnd_idle_timeout[%0d]: got %b, expected 1", it, ok);
            end
        end
        i_req = 1'b0; d_req = 1'b0;
        wait_idle(ok);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_i_read();
        test_tie();
        test_d_write();
        test_back_to_back();
        test_spurious_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
